// File: rtl/proc_pkg.sv
// proc_pkg: shared widths, opcodes, instruction fields and program ROM image
package proc_pkg;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_NOT  = 5'b00101;
    localparam logic [4:0] OP_SLL  = 5'b00110;
    localparam logic [4:0] OP_SRL  = 5'b00111;
    localparam logic [4:0] OP_SRA  = 5'b01000;
    localparam logic [4:0] OP_SLT  = 5'b01001;
    localparam logic [4:0] OP_SLTU = 5'b01010;
    localparam logic [4:0] OP_MOVA = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01100;
    localparam logic [4:0] OP_INC  = 5'b01101;
    localparam logic [4:0] OP_DEC  = 5'b01110;
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 27;
    localparam int RDST_MSB = 26;
    localparam int RDST_LSB = 22;
    localparam int RS2_MSB  = 9;
    localparam int RS2_LSB  = 5;
    localparam int RS1_MSB  = 4;
    localparam int RS1_LSB  = 0;
    // r1=r0+r0, r2=r1+1, r3=r2+r1, r4=r3-r2, r5=r3<<r2, r6=r5*r3, r7=r6^r1, r8=r7-1
    localparam logic [DW-1:0] PROG_ROM [0:31] = '{
        32'h0040_0000, 32'h6880_0001, 32'h00C0_0022, 32'h0900_0043,
        32'h3140_0043, 32'h6180_0065, 32'h21C0_0026, 32'h7200_0007,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0
    };
endpackage

// File: rtl/proc_alu.sv
// proc_alu: combinational 5-bit-opcode ALU, modulo-2^32 arithmetic
//   op [4:0] opcode, a/b [DW-1:0] operands, y [DW-1:0] result, zero = (y == 0)
module proc_alu
    import proc_pkg::*;
(
    input  logic [4:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y,
    output logic          zero
);
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_SLL:  y = a << b[4:0];
            OP_SRL:  y = a >> b[4:0];
            OP_SRA:  y = $signed(a) >>> b[4:0];
            OP_SLT:  y = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: y = {31'b0, a < b};
            OP_MOVA: y = a;
            OP_MUL:  y = a * b;
            OP_INC:  y = a + 32'd1;
            OP_DEC:  y = a - 32'd1;
            default: y = '0;
        endcase
    end
    assign zero = (y == '0);
endmodule

// File: rtl/proc_exec_mem_unit.sv
// proc_exec_mem_unit: instruction ROM, 32x32 data memory and ALU of the teaching processor
//   clock, reset_n         : clock and synchronous active-low reset (clears data memory only)
//   prog_addr -> prog_data : combinational ROM lookup
//   mem_addr, mem_wdata, mem_read -> mem_rdata : async read, write on posedge when mem_read=0
//   alu_op, alu_a, alu_b, alu_dst -> alu_out, alu_dst_o, alu_zero : combinational ALU
module proc_exec_mem_unit
    import proc_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic [AW-1:0] prog_addr,
    output logic [DW-1:0] prog_data,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    input  logic          mem_read,
    output logic [DW-1:0] mem_rdata,
    input  logic [4:0]    alu_op,
    input  logic [DW-1:0] alu_a,
    input  logic [DW-1:0] alu_b,
    input  logic [AW-1:0] alu_dst,
    output logic [DW-1:0] alu_out,
    output logic [AW-1:0] alu_dst_o,
    output logic          alu_zero
);
    logic [DW-1:0] mem [0:2**AW-1];

    assign prog_data = PROG_ROM[prog_addr];
    assign mem_rdata = mem[mem_addr];
    assign alu_dst_o = alu_dst;

    // reset wins over a same-cycle write
    always_ff @(posedge clock) begin
        if (!reset_n)
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        else if (!mem_read)
            mem[mem_addr] <= mem_wdata;
    end

    proc_alu u_alu (
        .op   (alu_op),
        .a    (alu_a),
        .b    (alu_b),
        .y    (alu_out),
        .zero (alu_zero)
    );
endmodule

// File: tb/tb_proc_exec_mem_unit.sv
// tb_proc_exec_mem_unit: directed self-checking bench for proc_exec_mem_unit
module tb_proc_exec_mem_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [4:0]  prog_addr = '0;
    logic [31:0] prog_data;
    logic [4:0]  mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_read = 1'b1;
    logic [31:0] mem_rdata;
    logic [4:0]  alu_op = '0;
    logic [31:0] alu_a = '0;
    logic [31:0] alu_b = '0;
    logic [4:0]  alu_dst = '0;
    logic [31:0] alu_out;
    logic [4:0]  alu_dst_o;
    logic        alu_zero;
    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    logic [31:0] rom_exp [0:31];

    always #5 clock = ~clock;

    proc_exec_mem_unit dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_dst   (alu_dst),
        .alu_out   (alu_out),
        .alu_dst_o (alu_dst_o),
        .alu_zero  (alu_zero)
    );

    task automatic test_reset;
        @(negedge clock);
        reset_n = 1'b0;
        mem_read = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mem_addr = 5'(i);
            #1;
            checks++;
            if (mem_rdata !== 32'h0) begin
                failures++;
                $display("FAIL reset_clear addr=%0d got=%h exp=%h", i, mem_rdata, 32'h0);
            end
        end
    endtask

    task automatic test_write_read;
        @(negedge clock);
        mem_addr = 5'd5;
        mem_wdata = 32'hDEADBEEF;
        mem_read = 1'b0;
        #1;
        checks++;
        if (mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL write_old_value got=%h exp=%h", mem_rdata, 32'h0);
        end
        @(posedge clock);
        #1;
        mem_read = 1'b1;
        #1;
        checks++;
        if (mem_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_new_value got=%h exp=%h", mem_rdata, 32'hDEADBEEF);
        end
        mem_addr = 5'd6;
        #1;
        checks++;
        if (mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL write_neighbour got=%h exp=%h", mem_rdata, 32'h0);
        end
    endtask

    task automatic test_reset_vs_write;
        @(negedge clock);
        mem_addr = 5'd3;
        mem_wdata = 32'h55;
        mem_read = 1'b0;
        @(posedge clock);
        #1;
        mem_read = 1'b1;
        #1;
        checks++;
        if (mem_rdata !== 32'h55) begin
            failures++;
            $display("FAIL prewrite got=%h exp=%h", mem_rdata, 32'h55);
        end
        @(negedge clock);
        reset_n = 1'b0;
        mem_wdata = 32'h1234;
        mem_read = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        mem_read = 1'b1;
        #1;
        checks++;
        if (mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_suppresses_write got=%h exp=%h", mem_rdata, 32'h0);
        end
        mem_addr = 5'd5;
        #1;
        checks++;
        if (mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_clears_other got=%h exp=%h", mem_rdata, 32'h0);
        end
    endtask

    task automatic test_alu_arith;
        vec_t v [11] = '{
            '{5'b00000, 32'hFFFFFFFF, 32'h1,     32'h0},
            '{5'b00000, 32'h2,        32'h3,     32'h5},
            '{5'b00001, 32'h3,        32'h5,     32'hFFFFFFFE},
            '{5'b01001, 32'hFFFFFFFF, 32'h1,     32'h1},
            '{5'b01001, 32'h1,        32'hFFFFFFFF, 32'h0},
            '{5'b01010, 32'hFFFFFFFF, 32'h1,     32'h0},
            '{5'b01010, 32'h1,        32'hFFFFFFFF, 32'h1},
            '{5'b01100, 32'h10000,    32'h10000, 32'h0},
            '{5'b01100, 32'h7,        32'h6,     32'h2A},
            '{5'b01101, 32'hFFFFFFFF, 32'h9,     32'h0},
            '{5'b01110, 32'h0,        32'h9,     32'hFFFFFFFF}
        };
        for (int i = 0; i < 11; i++) begin
            alu_op = v[i].op;
            alu_a = v[i].a;
            alu_b = v[i].b;
            #1;
            checks++;
            if (alu_out !== v[i].y || alu_zero !== (v[i].y == 32'h0)) begin
                failures++;
                $display("FAIL alu_arith op=%b a=%h b=%h got=%h/z%b exp=%h/z%b",
                         v[i].op, v[i].a, v[i].b, alu_out, alu_zero, v[i].y, v[i].y == 32'h0);
            end
        end
    endtask

    task automatic test_alu_logic;
        vec_t v [12] = '{
            '{5'b01000, 32'h80000000, 32'h4,  32'hF8000000},
            '{5'b01000, 32'h40000000, 32'h1,  32'h20000000},
            '{5'b00110, 32'h1,        32'h1F, 32'h80000000},
            '{5'b00111, 32'h80000000, 32'h4,  32'h08000000},
            '{5'b00111, 32'h80000000, 32'h24, 32'h08000000},
            '{5'b00010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000},
            '{5'b00011, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF},
            '{5'b00100, 32'hFFFF0000, 32'h0FF00FF0, 32'hF00F0FF0},
            '{5'b00101, 32'h12345678, 32'h0,  32'hEDCBA987},
            '{5'b01011, 32'hCAFEF00D, 32'h1,  32'hCAFEF00D},
            '{5'b11111, 32'h5,        32'h3,  32'h0},
            '{5'b01111, 32'h5,        32'h3,  32'h0}
        };
        for (int i = 0; i < 12; i++) begin
            alu_op = v[i].op;
            alu_a = v[i].a;
            alu_b = v[i].b;
            #1;
            checks++;
            if (alu_out !== v[i].y || alu_zero !== (v[i].y == 32'h0)) begin
                failures++;
                $display("FAIL alu_logic op=%b a=%h b=%h got=%h/z%b exp=%h/z%b",
                         v[i].op, v[i].a, v[i].b, alu_out, alu_zero, v[i].y, v[i].y == 32'h0);
            end
        end
        alu_dst = 5'd7;
        #1;
        checks++;
        if (alu_dst_o !== 5'd7) begin
            failures++;
            $display("FAIL alu_dst_pass got=%0d exp=%0d", alu_dst_o, 7);
        end
        alu_dst = 5'd26;
        #1;
        checks++;
        if (alu_dst_o !== 5'd26) begin
            failures++;
            $display("FAIL alu_dst_pass got=%0d exp=%0d", alu_dst_o, 26);
        end
    endtask

    task automatic rom_sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            prog_addr = 5'(i);
            #1;
            checks++;
            if (prog_data !== rom_exp[i]) begin
                failures++;
                $display("FAIL rom_%s addr=%0d got=%h exp=%h", tag, i, prog_data, rom_exp[i]);
            end
        end
    endtask

    task automatic test_rom;
        rom_sweep("sweep");
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        rom_sweep("after_reset");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_exp[i] = 32'h0;
        rom_exp[0] = 32'h00400000;
        rom_exp[1] = 32'h68800001;
        rom_exp[2] = 32'h00C00022;
        rom_exp[3] = 32'h09000043;
        rom_exp[4] = 32'h31400043;
        rom_exp[5] = 32'h61800065;
        rom_exp[6] = 32'h21C00026;
        rom_exp[7] = 32'h72000007;
        test_reset;
        test_write_read;
        test_reset_vs_write;
        test_alu_arith;
        test_alu_logic;
        test_rom;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
